// File: rtl/fin_period_counter_pkg.sv
// Shared types for the reciprocal frequency meter channel: FSM encoding, default widths
// and the majority helper used by the optional glitch filter (FIN_GLITCH_FILTER_EN).
package fin_period_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam int DEF_REF_W  = 30;
   localparam int DEF_PER_W  = 24;
   localparam int DEF_SYNC_N = 2;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/fin_input_sync.sv
// Synchronises one async Fin pin and emits a 1-cycle rising-edge strobe.
// FIN_GLITCH_FILTER_EN adds a 3-sample majority filter ahead of the edge detector.
module fin_input_sync
   import fin_period_counter_pkg::*;
#(
   parameter int SYNC_N = DEF_SYNC_N
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic fin_i,
   output logic strobe_o
);

   logic [SYNC_N-1:0] sync_q;
   logic              level;
   logic              prev_q;
   logic              strobe_q;

`ifdef FIN_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;

   // Two of the last three synced samples must agree, so a 1-clk pulse never wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], sync_q[SYNC_N-1]};
         filt_q <= maj3(sync_q[SYNC_N-1], hist_q[0], hist_q[1]);
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[SYNC_N-1];
`endif

   // NOTE: the synchroniser flops are reset too, so no X can reach the edge detector.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_N-2:0], fin_i};
         prev_q   <= level;
         strobe_q <= level & ~prev_q;
      end
   end

   assign strobe_o = strobe_q;

endmodule

// File: rtl/fin_period_counter.sv
// Per-channel reciprocal frequency meter: counts clk_i ticks over N input periods.
// Optional build macro FIN_GLITCH_FILTER_EN enables the input glitch filter.
module fin_period_counter
   import fin_period_counter_pkg::*;
#(
   parameter int REF_W  = DEF_REF_W,
   parameter int PER_W  = DEF_PER_W,
   parameter int SYNC_N = DEF_SYNC_N
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             fin_i,
   input  logic [PER_W-1:0] periods_i,
   input  logic             start_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic             timeout_o,
   output logic             overrun_o,
   output logic [REF_W-1:0] ref_cnt_o,
   output logic [PER_W-1:0] per_cnt_o
);

   localparam logic [REF_W-1:0] REF_LAST = {REF_W{1'b1}} - REF_W'(1);

   state_e           state_q;
   logic [PER_W-1:0] rem_q;
   logic [PER_W-1:0] per_q;
   logic [REF_W-1:0] ref_q;
   logic [REF_W-1:0] ref_res_q;
   logic [PER_W-1:0] per_res_q;
   logic             busy_q;
   logic             valid_q;
   logic             timeout_q;
   logic             overrun_q;
   logic             strobe;
   logic [PER_W-1:0] periods_eff;
   logic             arm;

   fin_input_sync #(
      .SYNC_N(SYNC_N)
   ) u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .fin_i   (fin_i),
      .strobe_o(strobe)
   );

   assign periods_eff = (periods_i == '0) ? PER_W'(1) : periods_i;
   assign arm = start_i && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && ack_i));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         per_q     <= '0;
         ref_q     <= '0;
         ref_res_q <= '0;
         per_res_q <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (ack_i) overrun_q <= 1'b0;
         if (start_i && !arm && (state_q != ST_IDLE)) overrun_q <= 1'b1;

         case (state_q)
            ST_IDLE: ;
            ST_ARM: begin
               ref_q <= ref_q + REF_W'(1);
               if (strobe) begin
                  state_q <= ST_MEASURE;
                  ref_q   <= '0;
                  per_q   <= '0;
               end else if (ref_q == REF_LAST) begin
                  state_q   <= ST_DONE;
                  busy_q    <= 1'b0;
                  valid_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  ref_res_q <= '1;
                  per_res_q <= '0;
               end
            end
            ST_MEASURE: begin
               ref_q <= ref_q + REF_W'(1);
               if (strobe) begin
                  per_q <= per_q + PER_W'(1);
                  rem_q <= rem_q - PER_W'(1);
               end
               // A completing edge wins over saturation: ref_q+1 still fits the counter.
               if (strobe && (rem_q == PER_W'(1))) begin
                  state_q   <= ST_DONE;
                  busy_q    <= 1'b0;
                  valid_q   <= 1'b1;
                  timeout_q <= 1'b0;
                  ref_res_q <= ref_q + REF_W'(1);
                  per_res_q <= per_q + PER_W'(1);
               end else if (ref_q == REF_LAST) begin
                  state_q   <= ST_DONE;
                  busy_q    <= 1'b0;
                  valid_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  ref_res_q <= '1;
                  per_res_q <= per_q + PER_W'(strobe);
               end
            end
            ST_DONE: begin
               if (ack_i) begin
                  state_q   <= ST_IDLE;
                  valid_q   <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
         endcase

         // NOTE: later non-blocking assignments win, so arming overrides the state updates above.
         if (arm) begin
            state_q   <= ST_ARM;
            rem_q     <= periods_eff;
            per_q     <= '0;
            ref_q     <= '0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
         end
      end
   end

   assign busy_o    = busy_q;
   assign valid_o   = valid_q;
   assign timeout_o = timeout_q;
   assign overrun_o = overrun_q;
   assign ref_cnt_o = ref_res_q;
   assign per_cnt_o = per_res_q;

endmodule

// File: tb/tb_fin_period_counter.sv
// Directed bench for fin_period_counter: table of square-wave measurements plus hand
// sequences for timeout, overrun, ack+start, reset abort and 1-clk pulse handling.
module tb_fin_period_counter;

   localparam int PER_W = 24;
   localparam int REF_W = 30;
   localparam int REF_S = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             fin, start, ack;
   logic [PER_W-1:0] periods;
   logic             busy, valid, timeout, overrun;
   logic [REF_W-1:0] ref_cnt;
   logic [PER_W-1:0] per_cnt;

   logic             fin8, start8, ack8;
   logic [PER_W-1:0] periods8;
   logic             busy8, valid8, timeout8, overrun8;
   logic [REF_S-1:0] ref_cnt8;
   logic [PER_W-1:0] per_cnt8;

   int n_checks = 0;
   int n_pass   = 0;

   int gen_period = 16, gen_hi = 8, phase = 0;
   bit gen_en = 1'b0;
   int gen8_period = 8, gen8_hi = 1, phase8 = 0;
   bit gen8_en = 1'b0;

   fin_period_counter #(.REF_W(REF_W), .PER_W(PER_W), .SYNC_N(2)) dut (
      .clk_i(clk), .rst_i(rst), .fin_i(fin), .periods_i(periods),
      .start_i(start), .ack_i(ack), .busy_o(busy), .valid_o(valid),
      .timeout_o(timeout), .overrun_o(overrun), .ref_cnt_o(ref_cnt), .per_cnt_o(per_cnt)
   );

   fin_period_counter #(.REF_W(REF_S), .PER_W(PER_W), .SYNC_N(2)) dut8 (
      .clk_i(clk), .rst_i(rst), .fin_i(fin8), .periods_i(periods8),
      .start_i(start8), .ack_i(ack8), .busy_o(busy8), .valid_o(valid8),
      .timeout_o(timeout8), .overrun_o(overrun8), .ref_cnt_o(ref_cnt8), .per_cnt_o(per_cnt8)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (!gen_en) begin
         fin   = 1'b0;
         phase = 0;
      end else begin
         fin   = (phase < gen_hi);
         phase = (phase + 1 == gen_period) ? 0 : phase + 1;
      end
   end

   always @(negedge clk) begin
      if (!gen8_en) begin
         fin8   = 1'b0;
         phase8 = 0;
      end else begin
         fin8   = (phase8 < gen8_hi);
         phase8 = (phase8 + 1 == gen8_period) ? 0 : phase8 + 1;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_wave(input int period, input int hi);
      gen_en = 1'b0;
      repeat (8) @(negedge clk);
      gen_period = period;
      gen_hi     = hi;
      gen_en     = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk) ack = 1'b1;
      @(negedge clk) ack = 1'b0;
   endtask

   task automatic wait_valid(input bit sel8, input int budget, output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < budget && !ok) begin
         @(posedge clk);
         #1;
         cyc++;
         ok = sel8 ? valid8 : valid;
      end
   endtask

   typedef struct {
      int periods;
      int period;
      int hi;
      int exp_ref;
      int exp_per;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int   cyc;
      bit   ok;

      vecs[0] = '{periods: 4, period: 16,   hi: 8,   exp_ref: 64,   exp_per: 4};
      vecs[1] = '{periods: 0, period: 1024, hi: 512, exp_ref: 1024, exp_per: 1};
      vecs[2] = '{periods: 1, period: 10,   hi: 5,   exp_ref: 10,   exp_per: 1};
      vecs[3] = '{periods: 7, period: 6,    hi: 3,   exp_ref: 42,   exp_per: 7};
      vecs[4] = '{periods: 3, period: 5,    hi: 2,   exp_ref: 15,   exp_per: 3};

      rst = 1'b1; start = 1'b0; ack = 1'b0; periods = '0;
      start8 = 1'b0; ack8 = 1'b0; periods8 = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, valid, timeout, overrun}, 4'b0);
      check("reset_ref", 64'(ref_cnt), 64'd0);
      check("reset_per", 64'(per_cnt), 64'd0);
      check("reset_outputs8", {busy8, valid8, timeout8, overrun8, ref_cnt8}, 12'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         int p_eff;
         p_eff = (vecs[i].periods == 0) ? 1 : vecs[i].periods;
         set_wave(vecs[i].period, vecs[i].hi);
         periods = PER_W'(vecs[i].periods);
         pulse_start();
         check($sformatf("vec%0d_busy", i), busy, 1'b1);
         periods = 24'h00ABCD;
         wait_valid(1'b0, (p_eff + 2) * vecs[i].period + 40, cyc, ok);
         check($sformatf("vec%0d_done", i), ok, 1'b1);
         check($sformatf("vec%0d_ref", i), 64'(ref_cnt), 64'(vecs[i].exp_ref));
         check($sformatf("vec%0d_per", i), 64'(per_cnt), 64'(vecs[i].exp_per));
         check($sformatf("vec%0d_flags", i), {busy, timeout, overrun}, 3'b000);
         pulse_ack();
         check($sformatf("vec%0d_release", i), {valid, busy}, 2'b00);
      end

      // Ref counter saturation with no input edges (8-bit instance).
      periods8 = 24'd3;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      wait_valid(1'b1, 400, cyc, ok);
      check("timeout_done", ok, 1'b1);
      check("timeout_cycles", 64'(cyc), 64'd255);
      check("timeout_flag", timeout8, 1'b1);
      check("timeout_ref", 64'(ref_cnt8), 64'hFF);
      check("timeout_per", 64'(per_cnt8), 64'd0);
      @(negedge clk) ack8 = 1'b1;
      @(negedge clk) ack8 = 1'b0;
      check("timeout_release", {valid8, timeout8}, 2'b00);

      // Overrun: start during MEASURE is ignored; ack clears the sticky flag.
      set_wave(16, 8);
      periods = 24'd4;
      pulse_start();
      repeat (30) @(negedge clk);
      check("ovr_pre", {busy, overrun}, 2'b10);
      pulse_start();
      check("ovr_set", {busy, overrun}, 2'b11);
      pulse_ack();
      check("ovr_ack_clears", {busy, valid, overrun}, 3'b100);
      pulse_start();
      check("ovr_set_again", overrun, 1'b1);
      wait_valid(1'b0, 200, cyc, ok);
      check("ovr_done", ok, 1'b1);
      check("ovr_ref", 64'(ref_cnt), 64'd64);
      check("ovr_per", 64'(per_cnt), 64'd4);
      check("ovr_sticky", overrun, 1'b1);
      pulse_ack();
      check("ovr_release", {valid, overrun}, 2'b00);

      // ack and start together in DONE re-arm immediately.
      periods = 24'd2;
      pulse_start();
      wait_valid(1'b0, 150, cyc, ok);
      check("ackstart_first_ref", 64'(ref_cnt), 64'd32);
      @(negedge clk);
      ack = 1'b1; start = 1'b1; periods = 24'd3;
      @(negedge clk);
      ack = 1'b0; start = 1'b0;
      check("ackstart_state", {busy, valid, overrun}, 3'b100);
      wait_valid(1'b0, 200, cyc, ok);
      check("ackstart_done", ok, 1'b1);
      check("ackstart_ref", 64'(ref_cnt), 64'd48);
      check("ackstart_per", 64'(per_cnt), 64'd3);
      check("ackstart_flags", {timeout, overrun}, 2'b00);
      pulse_ack();

      // Async reset aborts a measurement immediately.
      periods = 24'd4;
      pulse_start();
      repeat (20) @(negedge clk);
      pulse_start();
      check("rst_pre", {busy, overrun}, 2'b11);
      #2 rst = 1'b1;
      #1;
      check("rst_flags", {busy, valid, timeout, overrun}, 4'b0000);
      check("rst_ref", 64'(ref_cnt), 64'd0);
      check("rst_per", 64'(per_cnt), 64'd0);
      @(negedge clk) rst = 1'b0;
      repeat (40) @(negedge clk);
      check("rst_stays_idle", {busy, valid}, 2'b00);

      // 1-clk pulses every 8 clocks on the 8-bit instance.
      gen8_period = 8; gen8_hi = 1; gen8_en = 1'b1;
      periods8 = 24'd4;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      wait_valid(1'b1, 400, cyc, ok);
      check("glitch_done", ok, 1'b1);
`ifdef FIN_GLITCH_FILTER_EN
      check("glitch_timeout", timeout8, 1'b1);
      check("glitch_ref", 64'(ref_cnt8), 64'hFF);
      check("glitch_per", 64'(per_cnt8), 64'd0);
`else
      check("glitch_timeout", timeout8, 1'b0);
      check("glitch_ref", 64'(ref_cnt8), 64'd32);
      check("glitch_per", 64'(per_cnt8), 64'd4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
